stream_demux_1to2: RTL and testbench
====================================

STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

Interface
REQ-001 SHALL have parameter: DATA_WIDTH, default 8, width of each data word.
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port: in_data  input  DATA_WIDTH  word offered by upstream.
REQ-005 SHALL have port: in_sel  input  1  destination of in_data (0 = out 0, 1 = out 1).
REQ-006 SHALL have port: in_valid  input  1  upstream word valid.
REQ-007 SHALL have port: in_ready  output  1  block accepts the word this cycle.
REQ-008 SHALL have port: out_vec  output  DATA_WIDTH, unpacked [1:0]  head word of each output queue.
REQ-009 SHALL have port: out_valid  output  2  out_vec[i] valid.
REQ-010 SHALL have port: out_ready  input  2  downstream i consumes out_vec[i].
REQ-011 SHALL have port: out_empty  output  2  queue i holds 0 words.

Function
REQ-012 SHALL contain one independent 2-entry FIFO per output (i = 0, 1); occupancy per queue SHALL be 0, 1 or 2.
REQ-013 SHALL define input transfer as in_valid & in_ready at the clock edge; the word SHALL be written to queue in_sel only.
REQ-014 SHALL drive in_ready = (occupancy of queue in_sel < 2); in_ready SHALL NOT depend combinationally on out_ready.
REQ-015 SHALL hold the requirement that upstream keeps in_data and in_sel stable while in_valid=1 and in_ready=0.
REQ-016 SHALL define output transfer i as out_valid[i] & out_ready[i]; the head word SHALL be popped at that edge.
REQ-017 SHALL drive out_valid[i] = (occupancy i > 0) and out_empty[i] = (occupancy i == 0), both decoded from registered state.
REQ-018 SHALL drive out_vec[i] from the head entry of queue i; value is don't-care when out_valid[i]=0.
REQ-019 SHALL have one-cycle latency: a word accepted at edge N appears on out_vec[in_sel] with out_valid high after edge N, if queue was empty.
REQ-020 SHALL preserve per-output FIFO order; no ordering is defined between the two outputs.
REQ-021 SHALL, on simultaneous push and pop of the same queue, leave occupancy unchanged and advance both pointers.
REQ-022 SHALL, with queue i full, refuse pushes to i even when out_ready[i]=1 in the same cycle (occupancy goes 2->1, push accepted next cycle).
REQ-023 SHALL let a push to one queue and a pop of the other occur in the same cycle independently.
REQ-024 SHALL use 1-bit read/write pointers per queue that wrap 1->0; occupancy SHALL never exceed 2 or underflow below 0.
REQ-025 SHALL ignore out_ready[i] when out_valid[i]=0 (no state change).
REQ-026 SHALL drop no words: every accepted word is presented exactly once on its selected output.

Reset
REQ-027 SHALL, on reset assertion (asynchronous, any cycle, including mid-transfer), clear all occupancies and pointers to 0.
REQ-028 SHALL drive during and after reset: out_valid=2'b00, out_empty=2'b11, in_ready=1; queue storage contents need not be reset.
REQ-029 SHALL discard all queued words on reset; the first accepted word after reset deassertion is the first word out.

Structure
REQ-030 SHALL instantiate the sub-module fifo_2entry (parameter DATA_WIDTH; push, pop, data in/out, full, empty) twice, once per output.
REQ-031 SHALL need no shared-package typedefs; FIFO depth 2 is a local constant inside fifo_2entry.

Verification
REQ-032 SHALL cover: reset mid-stream with queue 1 at 2 words -> next cycle out_valid=00, out_empty=11, in_ready=1.
REQ-033 SHALL cover: push 0x11 sel=0, 0x22 sel=1, out_ready=00 -> out_vec[0]=0x11, out_vec[1]=0x22, out_valid=11 one cycle after each push.
REQ-034 SHALL cover: out_ready[0]=0, push 0xA1, 0xA2, 0xA3 with sel=0 -> 0xA3 stalled (in_ready=0); set out_ready[0]=1 -> output order 0xA1, 0xA2, 0xA3, 0xA3 accepted one cycle after first pop.
REQ-035 SHALL cover: queue 0 full, in_sel=1 -> in_ready=1, word 0x5C accepted into queue 1 unaffected.
REQ-036 SHALL cover: queue 1 holding one word, simultaneous push 0x33 sel=1 and pop -> occupancy stays 1, out_vec[1]=0x33 next cycle.
REQ-037 SHALL cover: 1000 random words, random sel/valid/out_ready -> per-output scoreboard matches in order, zero loss or duplication.

Source files
------------

// File: rtl/stream_demux_1to2_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_1to2_pkg
//   Shared constants and helpers for the 1-to-2 stream demultiplexer.
//   The FIFO depth stays private to fifo_2entry. This package only carries
//   the fan-out count and the routing decode that the top level uses.
// -----------------------------------------------------------------------------
package stream_demux_1to2_pkg;

   // Number of output streams the demux fans out to.
   localparam int NUM_OUTS = 2;

   // True when a word steered by 'sel' belongs to output 'idx'.
   function automatic logic routed_to(input logic sel, input int idx);
      return (int'(sel) == idx);
   endfunction

endpackage

// File: rtl/fifo_2entry.sv
// -----------------------------------------------------------------------------
// fifo_2entry
//   Two-entry synchronous FIFO with a registered occupancy count.
//   The read and write pointers are single bits, so they wrap from 1 back
//   to 0 without any extra logic. A push while full is ignored, and so is
//   a pop while empty. This keeps the occupancy within 0..2 even if the
//   caller does not gate its requests.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset of pointers and count
//   push       : write push_data this cycle (ignored when full)
//   push_data  : word to store
//   pop        : discard the head word this cycle (ignored when empty)
//   pop_data   : head word; don't-care when empty
//   full       : two words held
//   empty      : no words held
// -----------------------------------------------------------------------------
module fifo_2entry #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] pop_data,
   output logic                  full,
   output logic                  empty
);

   localparam int          DEPTH     = 2;
   localparam logic [1:0]  COUNT_MAX = 2'(DEPTH);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            count;
   logic                  do_push;
   logic                  do_pop;

   assign full    = (count == COUNT_MAX);
   assign empty   = (count == 2'd0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Control state: pointers and occupancy. A simultaneous push and pop
   // advances both pointers and leaves the count unchanged.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) wr_ptr <= ~wr_ptr;
         if (do_pop)  rd_ptr <= ~rd_ptr;
         case ({do_push, do_pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Storage is data only. A reset empties the queue through the count,
   // so the stale contents are never observed.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// stream_demux_1to2
//   Routes one valid/ready input stream to one of two outputs. Each output
//   has its own 2-entry FIFO, so a stall on one output never blocks words
//   bound for the other.
//   in_ready depends only on the registered fullness of the selected queue,
//   never on out_ready. A full queue therefore refuses a push even in a
//   cycle where it is being drained. The push is accepted one cycle later.
//
// Ports
//   clk        : rising-edge clock
//   reset      : asynchronous active-high reset; empties both queues
//   in_data    : word offered by upstream
//   in_sel     : destination of in_data (0 -> out 0, 1 -> out 1)
//   in_valid   : upstream word valid
//   in_ready   : selected queue has room this cycle
//   out_vec    : head word of each queue (don't-care when not valid)
//   out_valid  : queue i holds at least one word
//   out_ready  : downstream i consumes out_vec[i]
//   out_empty  : queue i holds no words
// -----------------------------------------------------------------------------
module stream_demux_1to2
   import stream_demux_1to2_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_sel,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_vec [1:0],
   output logic [1:0]            out_valid,
   input  logic [1:0]            out_ready,
   output logic [1:0]            out_empty
);

   logic [NUM_OUTS-1:0] push;
   logic [NUM_OUTS-1:0] pop;
   logic [NUM_OUTS-1:0] full;
   logic [NUM_OUTS-1:0] empty;
   logic                in_xfer;

   assign in_ready = ~full[in_sel];
   assign in_xfer  = in_valid & in_ready;

   for (genvar i = 0; i < NUM_OUTS; i++) begin : g_out
      // Pops are qualified by occupancy, so out_ready on an idle output
      // has no effect.
      assign push[i] = in_xfer & routed_to(in_sel, i);
      assign pop[i]  = out_ready[i] & ~empty[i];

      fifo_2entry #(
         .DATA_WIDTH (DATA_WIDTH)
      ) u_fifo (
         .clk       (clk),
         .reset     (reset),
         .push      (push[i]),
         .push_data (in_data),
         .pop       (pop[i]),
         .pop_data  (out_vec[i]),
         .full      (full[i]),
         .empty     (empty[i])
      );

      assign out_valid[i] = ~empty[i];
      assign out_empty[i] = empty[i];
   end

endmodule

// File: tb/tb_stream_demux_1to2.sv
// -----------------------------------------------------------------------------
// tb_stream_demux_1to2
//   Bench for stream_demux_1to2. The reference holds each output's pending
//   words in a queue. Every cycle it is checked against the DUT's handshake
//   and head-word outputs. Directed sequences pin known literal values.
//   A randomized phase then pushes 1000 words through the design.
// -----------------------------------------------------------------------------
module tb_stream_demux_1to2;

   localparam int DW = 8;

   logic          clk       = 1'b0;
   logic          reset     = 1'b1;
   logic [DW-1:0] in_data   = '0;
   logic          in_sel    = 1'b0;
   logic          in_valid  = 1'b0;
   logic          in_ready;
   logic [DW-1:0] out_vec [1:0];
   logic [1:0]    out_valid;
   logic [1:0]    out_ready = 2'b00;
   logic [1:0]    out_empty;

   stream_demux_1to2 #(.DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_vec   (out_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_empty (out_empty)
   );

   always #5 clk = ~clk;

   int n_checks   = 0;
   int n_fail     = 0;
   int pushes     = 0;
   int dut_pops   = 0;
   int discarded  = 0;

   logic [DW-1:0] q0 [$];
   logic [DW-1:0] q1 [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: each queue is the list of words accepted for that output
   // and not yet consumed. The DUT is compared at the falling edge. The
   // transfers that the next rising edge will perform are then applied.
   always @(negedge clk) begin : model
      int  s0, s1, ssel;
      logic do_push, do_p0, do_p1;
      if (reset) begin
         discarded += q0.size() + q1.size();
         q0.delete();
         q1.delete();
      end
      s0   = q0.size();
      s1   = q1.size();
      ssel = in_sel ? s1 : s0;
      chk("m_out_valid", {30'd0, out_valid}, {30'd0, (s1 > 0), (s0 > 0)});
      chk("m_out_empty", {30'd0, out_empty}, {30'd0, (s1 == 0), (s0 == 0)});
      chk("m_in_ready", {31'd0, in_ready}, {31'd0, (ssel < 2)});
      if (s0 > 0) chk("m_out_vec0", {24'd0, out_vec[0]}, {24'd0, q0[0]});
      if (s1 > 0) chk("m_out_vec1", {24'd0, out_vec[1]}, {24'd0, q1[0]});
      if (!reset) begin
         do_push = in_valid && (ssel < 2);
         do_p0   = out_ready[0] && (s0 > 0);
         do_p1   = out_ready[1] && (s1 > 0);
         if (out_valid[0] && out_ready[0]) dut_pops++;
         if (out_valid[1] && out_ready[1]) dut_pops++;
         if (do_p0) void'(q0.pop_front());
         if (do_p1) void'(q1.pop_front());
         if (do_push) begin
            if (in_sel) q1.push_back(in_data);
            else        q0.push_back(in_data);
            pushes++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic s, input logic [DW-1:0] d);
      in_valid = v;
      in_sel   = s;
      in_data  = d;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int   cyc;
      int   base;
      logic held;

      // Reset state
      repeat (2) tick();
      chk("rst_out_valid", {30'd0, out_valid}, 32'h0);
      chk("rst_out_empty", {30'd0, out_empty}, 32'h3);
      chk("rst_in_ready", {31'd0, in_ready}, 32'h1);
      reset = 1'b0;
      tick();

      // One word to each output, one-cycle latency
      out_ready = 2'b00;
      drive(1'b1, 1'b0, 8'h11); tick();
      chk("p11_valid", {30'd0, out_valid}, 32'h1);
      chk("p11_vec0", {24'd0, out_vec[0]}, 32'h11);
      drive(1'b1, 1'b1, 8'h22); tick();
      chk("p22_valid", {30'd0, out_valid}, 32'h3);
      chk("p22_vec0", {24'd0, out_vec[0]}, 32'h11);
      chk("p22_vec1", {24'd0, out_vec[1]}, 32'h22);
      drive(1'b0, 1'b0, 8'h00); out_ready = 2'b11; tick();
      chk("p22_drained", {30'd0, out_empty}, 32'h3);
      out_ready = 2'b00;

      // Full queue 0 stalls, then drains in order
      drive(1'b1, 1'b0, 8'hA1); tick();
      drive(1'b1, 1'b0, 8'hA2); tick();
      drive(1'b1, 1'b0, 8'hA3); #1;
      chk("a3_stall_ready", {31'd0, in_ready}, 32'h0);
      chk("a1_head", {24'd0, out_vec[0]}, 32'hA1);
      out_ready = 2'b01; tick();
      chk("a2_head", {24'd0, out_vec[0]}, 32'hA2);
      chk("a3_ready_after_pop", {31'd0, in_ready}, 32'h1);
      tick();
      chk("a3_head", {24'd0, out_vec[0]}, 32'hA3);
      chk("a3_valid", {30'd0, out_valid}, 32'h1);
      drive(1'b0, 1'b0, 8'h00); tick();
      chk("a_drained", {30'd0, out_empty}, 32'h3);
      out_ready = 2'b00;

      // Queue 0 full does not block queue 1
      drive(1'b1, 1'b0, 8'hB1); tick();
      drive(1'b1, 1'b0, 8'hB2); tick();
      drive(1'b1, 1'b1, 8'h5C); #1;
      chk("q1_ready_q0_full", {31'd0, in_ready}, 32'h1);
      tick();
      chk("q1_5c", {24'd0, out_vec[1]}, 32'h5C);
      chk("q1_5c_valid", {30'd0, out_valid}, 32'h3);
      chk("q0_b1_kept", {24'd0, out_vec[0]}, 32'hB1);
      drive(1'b0, 1'b0, 8'h00); out_ready = 2'b11; tick(); tick();
      chk("b_drained", {30'd0, out_empty}, 32'h3);
      out_ready = 2'b00;

      // Simultaneous push and pop on queue 1 keeps occupancy at 1
      drive(1'b1, 1'b1, 8'h77); tick();
      drive(1'b1, 1'b1, 8'h33); out_ready = 2'b10; tick();
      chk("pp_vec1", {24'd0, out_vec[1]}, 32'h33);
      chk("pp_valid", {30'd0, out_valid}, 32'h2);
      drive(1'b0, 1'b0, 8'h00); out_ready = 2'b00; tick();
      chk("pp_still_one", {30'd0, out_valid}, 32'h2);
      out_ready = 2'b10; tick();
      chk("pp_drained", {30'd0, out_empty}, 32'h3);
      out_ready = 2'b00;

      // Reset mid-stream with queue 1 full
      drive(1'b1, 1'b1, 8'hC1); tick();
      drive(1'b1, 1'b1, 8'hC2); tick();
      drive(1'b1, 1'b1, 8'hC3); #1;
      chk("c_full_ready", {31'd0, in_ready}, 32'h0);
      drive(1'b0, 1'b0, 8'h00);
      reset = 1'b1; #1;
      chk("rst_async_valid", {30'd0, out_valid}, 32'h0);
      tick();
      chk("rst_mid_valid", {30'd0, out_valid}, 32'h0);
      chk("rst_mid_empty", {30'd0, out_empty}, 32'h3);
      chk("rst_mid_ready", {31'd0, in_ready}, 32'h1);
      reset = 1'b0;
      drive(1'b1, 1'b1, 8'hD0); tick();
      chk("post_rst_first", {24'd0, out_vec[1]}, 32'hD0);
      drive(1'b0, 1'b0, 8'h00); out_ready = 2'b11; tick();
      out_ready = 2'b00;

      // Randomized traffic: 1000 accepted words
      base = pushes;
      cyc  = 0;
      held = 1'b0;
      while ((pushes - base) < 1000 && cyc < 20000) begin
         if (!held) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
         end
         out_ready = 2'($urandom_range(0, 3));
         #1;
         held = in_valid && !in_ready;
         tick();
         cyc++;
      end
      chk("rand_within_budget", {31'd0, (cyc < 20000)}, 32'h1);
      drive(1'b0, 1'b0, 8'h00);
      out_ready = 2'b11;
      repeat (4) tick();
      chk("rand_drained", {30'd0, out_empty}, 32'h3);
      chk("no_loss_no_dup", dut_pops + discarded, pushes);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
